// File: rtl/softmax_max_norm.sv
// softmax_max_norm: collects a 4-element signed fixed-point vector, tracks its maximum and
// presents each element minus the maximum (saturated) as registered outputs with a
// valid/ready handshake. This result is the max-normalisation step ahead of a softmax.
module softmax_max_norm #(
    parameter int WIDTH         = 32,
    parameter int FRAC_WIDTH    = 16,
    parameter int TOTAL_ELEMENT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_data,
    input  logic                    in_last,
    output logic signed [WIDTH-1:0] N1,
    output logic signed [WIDTH-1:0] N2,
    output logic signed [WIDTH-1:0] N3,
    output logic signed [WIDTH-1:0] N4,
    output logic signed [WIDTH-1:0] max_out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    err_len
);

    localparam int CntW = $clog2(TOTAL_ELEMENT);
    localparam logic [CntW-1:0] LastIdx = CntW'(TOTAL_ELEMENT - 1);

    // The datapath is hard-wired for four elements. The fraction width only labels the format.
    if (TOTAL_ELEMENT != 4 || FRAC_WIDTH > WIDTH) begin : g_bad_params
        $error("softmax_max_norm: TOTAL_ELEMENT must be 4 and FRAC_WIDTH <= WIDTH");
    end

    typedef enum logic [1:0] {
        StCollect = 2'd0,
        StSub     = 2'd1,
        StOut     = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic signed [WIDTH-1:0] data_q [4];
    logic signed [WIDTH-1:0] data_d [4];
    logic signed [WIDTH-1:0] max_q, max_d;
    logic signed [WIDTH-1:0] n_q [4];
    logic signed [WIDTH-1:0] n_d [4];
    logic signed [WIDTH-1:0] max_out_q, max_out_d;
    logic                    out_valid_q, out_valid_d;
    logic                    err_len_q, err_len_d;
    logic                    accept;

    // a - b computed one bit wider, clamped back into the signed WIDTH range.
    function automatic logic signed [WIDTH-1:0] sat_sub(input logic signed [WIDTH-1:0] a,
                                                        input logic signed [WIDTH-1:0] b);
        logic [WIDTH:0] d;
        d = {a[WIDTH-1], a} - {b[WIDTH-1], b};
        if (d[WIDTH] != d[WIDTH-1]) begin
            if (d[WIDTH]) begin
                return {1'b1, {(WIDTH-1){1'b0}}};
            end else begin
                return {1'b0, {(WIDTH-1){1'b1}}};
            end
        end
        return d[WIDTH-1:0];
    endfunction

    // in_ready is decoded from state and forced low while reset is held.
    assign in_ready = (state_q == StCollect) && !rst;
    assign accept   = in_valid && in_ready;

    // Next-state logic: element collection, subtraction and the output handshake.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        max_d       = max_q;
        n_d         = n_q;
        max_out_d   = max_out_q;
        out_valid_d = out_valid_q;
        err_len_d   = 1'b0;

        unique case (state_q)
            StCollect: begin
                if (accept) begin
                    data_d[cnt_q] = in_data;
                    // The first element seeds the max, so stale data never leaks in.
                    if (cnt_q == '0 || in_data > max_q) begin
                        max_d = in_data;
                    end
                    if (cnt_q == LastIdx) begin
                        state_d   = StSub;
                        cnt_d     = '0;
                        err_len_d = !in_last;
                    end else if (in_last) begin
                        // Short vector: drop it and restart at element 0.
                        cnt_d     = '0;
                        err_len_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StSub: begin
                for (int i = 0; i < 4; i++) begin
                    n_d[i] = sat_sub(data_q[i], max_q);
                end
                max_out_d   = max_q;
                out_valid_d = 1'b1;
                state_d     = StOut;
            end
            StOut: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StCollect;
                end
            end
            default: begin
                state_d     = StCollect;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset that clears everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StCollect;
            cnt_q       <= '0;
            max_q       <= '0;
            max_out_q   <= '0;
            out_valid_q <= 1'b0;
            err_len_q   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= '0;
                n_q[i]    <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            max_q       <= max_d;
            max_out_q   <= max_out_d;
            out_valid_q <= out_valid_d;
            err_len_q   <= err_len_d;
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= data_d[i];
                n_q[i]    <= n_d[i];
            end
        end
    end

    assign N1        = n_q[0];
    assign N2        = n_q[1];
    assign N3        = n_q[2];
    assign N4        = n_q[3];
    assign max_out   = max_out_q;
    assign out_valid = out_valid_q;
    assign err_len   = err_len_q;

endmodule

// File: tb/tb_softmax_max_norm.sv
// Scoreboard bench for softmax_max_norm: directed vectors push expected results, and a
// monitor pops and compares on each output handshake.
module tb_softmax_max_norm;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        in_last = 1'b0;
    logic [31:0] n1, n2, n3, n4, max_out;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        err_len;

    typedef struct packed {
        logic [31:0] n1;
        logic [31:0] n2;
        logic [31:0] n3;
        logic [31:0] n4;
        logic [31:0] mx;
    } exp_t;

    exp_t sb[$];
    int   checks  = 0;
    int   errors  = 0;
    int   err_cnt = 0;
    int   err_base;

    softmax_max_norm #(
        .WIDTH        (32),
        .FRAC_WIDTH   (16),
        .TOTAL_ELEMENT(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .N1       (n1),
        .N2       (n2),
        .N3       (n3),
        .N4       (n4),
        .max_out  (max_out),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .err_len  (err_len)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare on every output handshake and count err_len pulses.
    always @(negedge clk) begin
        if (err_len) err_cnt++;
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got out_valid 1 expected no output at %0t",
                         $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("N1", n1, e.n1);
                check("N2", n2, e.n2);
                check("N3", n3, e.n3);
                check("N4", n4, e.n4);
                check("max_out", max_out, e.mx);
            end
        end
    end

    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                        input logic [31:0] d, input logic [31:0] m);
        exp_t e;
        e.n1 = a; e.n2 = b; e.n3 = c; e.n4 = d; e.mx = m;
        sb.push_back(e);
    endtask

    task automatic send_elem(input logic [31:0] d, input logic l);
        int g;
        g = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(negedge clk);
        while (!in_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready 0 expected 1 at %0t", $time);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_vec(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                            input logic [31:0] d, input logic last4);
        send_elem(a, 1'b0);
        send_elem(b, 1'b0);
        send_elem(c, 1'b0);
        send_elem(d, last4);
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while (sb.size() != 0 && g < 30) begin
            @(posedge clk);
            g++;
        end
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
    endtask

    initial begin
        // Reset state
        #1 rst = 1'b1;
        #2;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_err_len", 32'(err_len), 32'd0);
        check("rst_N1", n1, 32'h0);
        check("rst_max_out", max_out, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Ascending vector with latency checks
        push(32'hFFFD0000, 32'hFFFE0000, 32'hFFFF0000, 32'h0, 32'h00040000);
        send_vec(32'h00010000, 32'h00020000, 32'h00030000, 32'h00040000, 1'b1);
        check("lat_t_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check("lat_t1_out_valid", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        check("lat_t2_out_valid", 32'(out_valid), 32'd0);
        check("lat_t2_in_ready", 32'(in_ready), 32'd1);
        wait_drain();

        // All negative
        push(32'hFFFC0000, 32'h0, 32'hFFFA0000, 32'hFFFF0000, 32'hFFFF0000);
        send_vec(32'hFFFB0000, 32'hFFFF0000, 32'hFFF90000, 32'hFFFE0000, 1'b1);
        wait_drain();

        // Saturation
        push(32'h80000000, 32'h0, 32'h80000001, 32'h80000001, 32'h7FFFFFFF);
        send_vec(32'h80000000, 32'h7FFFFFFF, 32'h0, 32'h0, 1'b1);
        wait_drain();

        // Backpressure: 3.0, -1.0, 0.5, 2.0 held for 5 cycles
        out_ready = 1'b0;
        push(32'h0, 32'hFFFC0000, 32'hFFFD8000, 32'hFFFF0000, 32'h00030000);
        send_vec(32'h00030000, 32'hFFFF0000, 32'h00008000, 32'h00020000, 1'b1);
        begin
            int g;
            g = 0;
            while (!out_valid && g < 20) begin
                @(negedge clk);
                g++;
            end
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_data  = 32'h12345678;
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_N3", n3, 32'hFFFD8000);
            check("bp_max_out", max_out, 32'h00030000);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_drain();
        push(32'hFFFD0000, 32'hFFFE0000, 32'hFFFF0000, 32'h0, 32'h00040000);
        send_vec(32'h00010000, 32'h00020000, 32'h00030000, 32'h00040000, 1'b1);
        wait_drain();

        // Short vector: in_last on the 2nd element
        err_base = err_cnt;
        send_elem(32'h00050000, 1'b0);
        send_elem(32'h00060000, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("short_err_pulses", 32'(err_cnt - err_base), 32'd1);
        check("short_no_valid", 32'(out_valid), 32'd0);
        push(32'h0, 32'hFFFE0000, 32'hFFFE0000, 32'hFFFE0000, 32'h00020000);
        send_vec(32'h00020000, 32'h0, 32'h0, 32'h0, 1'b1);
        wait_drain();

        // Missing in_last on the 4th element still completes but flags an error
        err_base = err_cnt;
        push(32'hFFFFFFF0, 32'h0, 32'hFFFFFFE5, 32'hFFFFFFE0, 32'h00000020);
        send_vec(32'h00000010, 32'h00000020, 32'h00000005, 32'h0, 1'b0);
        wait_drain();
        check("nolast_err_pulses", 32'(err_cnt - err_base), 32'd1);

        // Reset mid-collect
        send_elem(32'h00090000, 1'b0);
        send_elem(32'h00080000, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        check("mid_rst_max_out", max_out, 32'h0);
        check("mid_rst_N2", n2, 32'h0);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check("mid_rst_in_ready_held", 32'(in_ready), 32'd0);
        rst = 1'b0;
        push(32'hFFFD0000, 32'hFFFE0000, 32'hFFFF0000, 32'h0, 32'h00040000);
        send_vec(32'h00010000, 32'h00020000, 32'h00030000, 32'h00040000, 1'b1);
        wait_drain();

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/softmax_max_norm.md
SOFTMAX_MAX_NORM -- requirements
Module: softmax_max_norm

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data word width, signed fixed point.
REQ-002 SHALL have parameter FRAC_WIDTH, default 16: fractional bits (Q16.16 at defaults); informational only, no arithmetic depends on it.
REQ-003 SHALL have parameter TOTAL_ELEMENT, default 4: elements per vector; this block SHALL support only the value 4.
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port in_valid, input, 1 bit: in_data and in_last are valid.
REQ-008 SHALL have port in_ready, output, 1 bit: the block accepts an element this cycle.
REQ-009 SHALL have port in_data, input, WIDTH bits, signed: one vector element.
REQ-010 SHALL have port in_last, input, 1 bit: marks the final element of a vector.
REQ-011 SHALL have ports N1, N2, N3, N4, output, WIDTH bits each, signed: normalized elements x_i - max.
REQ-012 SHALL have port max_out, output, WIDTH bits, signed: vector maximum.
REQ-013 SHALL have port out_valid, output, 1 bit: N1..N4 and max_out are valid; this drives the softmax start.
REQ-014 SHALL have port out_ready, input, 1 bit: downstream consumes the outputs.
REQ-015 SHALL have port err_len, output, 1 bit: one-cycle pulse on a vector-length violation.

Function
REQ-016 SHALL implement the FSM states COLLECT, SUB and OUT, with COLLECT as the reset state.
REQ-017 An input accept SHALL occur when in_valid && in_ready; in_ready SHALL be 1 only in COLLECT while rst is low.
REQ-018 COLLECT: on each accept, the block SHALL store in_data into buffer[cnt] and increment a 2-bit counter cnt.
REQ-019 COLLECT: the accept at cnt==0 SHALL load the running max unconditionally; later accepts SHALL replace it if in_data > max (signed compare).
REQ-020 COLLECT: the accept at cnt==3 SHALL complete the vector; next state SUB, cnt SHALL return to 0.
REQ-021 COLLECT: if in_last=1 on an accept with cnt<3, the block SHALL discard the partial vector, set cnt=0, stay in COLLECT, and pulse err_len the following cycle.
REQ-022 COLLECT: if in_last=0 on the accept at cnt==3, the vector SHALL still complete normally, and err_len SHALL pulse the following cycle.
REQ-023 SUB (exactly one cycle): the block SHALL register N_i = buffer[i-1] - max in WIDTH+1 bits, saturated to the signed WIDTH range (below min gives 0x80..0; the result can never exceed 0), register max_out = max, then go to OUT.
REQ-024 OUT: out_valid SHALL be 1, and N1..N4 and max_out SHALL be held stable.
REQ-025 OUT: on out_ready=1 the block SHALL return to COLLECT, and out_valid SHALL be 0 on the next cycle.
REQ-026 OUT: with out_ready=0 the block SHALL hold indefinitely and in_data SHALL be ignored.
REQ-027 Latency: if the 4th element is accepted at edge t, out_valid SHALL rise after edge t+1; with out_ready held high, in_ready SHALL return after edge t+2.
REQ-028 Outputs SHALL be registered, except in_ready, which is decoded from state and rst.
REQ-029 Outputs SHALL keep the last vector's values while in COLLECT.
REQ-030 The block SHALL have no combinational path from in_* to out_*.

Reset
REQ-031 rst=1 SHALL, asynchronously: set state=COLLECT, cnt=0, buffer=0, max=0, N1..N4=0, max_out=0, out_valid=0, err_len=0.
REQ-032 rst=1 SHALL force in_ready=0.
REQ-033 Reset mid-vector or in OUT SHALL abandon all data; the first accept after release SHALL be treated as element 0.

Verification
REQ-034 Ascending vector: 1.0, 2.0, 3.0, 4.0 (0x00010000..0x00040000, in_last on 4th), out_ready=1 -> N1..N4 = 0xFFFD0000, 0xFFFE0000, 0xFFFF0000, 0x00000000; max_out=0x00040000; out_valid high exactly one cycle, two edges after the last accept.
REQ-035 All negative: -5.0, -1.0, -7.0, -2.0 -> max_out=0xFFFF0000; N = 0xFFFC0000, 0x00000000, 0xFFFA0000, 0xFFFF0000.
REQ-036 Saturation: 0x80000000, 0x7FFFFFFF, 0x00000000, 0x00000000 -> N1=0x80000000 (saturated), N2=0, N3=0x80000001, N4=0x80000001.
REQ-037 Backpressure: out_ready=0 for 5 cycles in OUT while in_valid=1 -> out_valid, N*, max_out constant; in_ready=0; no elements consumed; the next vector after out_ready is processed correctly.
REQ-038 Length error: in_last on the 2nd element -> err_len pulses once; no out_valid; the following vector 2.0, 0, 0, 0 gives N = 0, 0xFFFE0000, 0xFFFE0000, 0xFFFE0000.
REQ-039 Reset mid-collect: rst pulsed after 2 accepts -> all outputs 0 immediately; in_ready=0 during rst; the next 4-element vector matches REQ-034.
